next_pc_controller: RTL and testbench
=====================================

// Module: next_pc_controller
// PURPOSE
// - Sequences the next-PC adder/mux from EX-stage branch/jump resolution.
// - Selects the target source (branch adder, jr register A, jump address), asserts the PC redirect,
//   and squashes wrong-path instructions in IF/ID and ID/EX.
// - Holds a pending redirect while the front end is stalled.
// - Sits between EX-stage decode/compare outputs and the PC register / IF-ID, ID-EX pipeline registers.
// PARAMETERS
// - FLUSH_CYCLES  2   cycles flush_o stays high, counted from the redirect cycle; legal range 1..7
// - CNT_W         16  width of the redirect statistics counter
// PORTS
// - Clk             in   1      clock, rising edge
// - Reset_n         in   1      async active-low reset
// - ex_valid_i      in   1      EX holds a valid, non-squashed instruction
// - ex_branch_i     in   1      EX instruction is a conditional branch
// - ex_taken_i      in   1      branch condition true; ignored unless ex_branch_i
// - ex_jr_i         in   1      EX instruction is jr (target = register A)
// - ex_jump_i       in   1      EX instruction is j/jal (target = JAddress)
// - pc_stall_i      in   1      front end frozen; PC and EX operands are held this cycle
// - adder_ctrl_o    out  2      control to next-PC adder: 0 = branch target, 1 = A, 2 = JAddress; 3 never driven
// - redirect_o      out  1      PC loads the adder output at the next edge
// - flush_o         out  1      clear IF/ID and ID/EX at the next edge
// - busy_o          out  1      state != IDLE
// - multi_err_o     out  1      sticky: more than one of jump/jr/taken-branch seen together
// - redirect_cnt_o  out  CNT_W  saturating count of redirects issued
// BEHAVIOUR
// Interface and reset
// - One clock; reset is asynchronous and active-low.
// - Reset (asynchronous assert, synchronous release): state = IDLE, sel_q = 0, flush count = 0,
//   counter = 0, multi_err_o = 0.
// - After reset: adder_ctrl_o = 0, redirect_o = 0, flush_o = 0, busy_o = 0.
// - Reset mid-HOLD/FLUSH drops the pending redirect; no partial outputs.
// Request and priority
// - req = ex_valid_i & (ex_jump_i | ex_jr_i | (ex_branch_i & ex_taken_i)).
// - Source priority: jump (2) > jr (1) > taken branch (0).
// - Two or more of these true with ex_valid_i sets multi_err_o, held until reset.
// States
// - IDLE:
//   - req & !pc_stall_i: redirect_o = 1 and flush_o = 1 combinationally (Mealy).
//     adder_ctrl_o = the new selection this cycle. Capture sel_q.
//     Next state FLUSH if FLUSH_CYCLES > 1, otherwise IDLE.
//   - req & pc_stall_i: capture sel_q, go to HOLD. redirect_o = 0, flush_o = 0.
//   - no req: adder_ctrl_o = sel_q, redirect_o = 0, flush_o = 0.
// - HOLD:
//   - adder_ctrl_o = sel_q; new EX requests are ignored.
//   - When pc_stall_i falls: redirect_o = 1 and flush_o = 1 that cycle, then FLUSH (or IDLE if
//     FLUSH_CYCLES = 1).
// - FLUSH:
//   - flush_o = 1, redirect_o = 0, adder_ctrl_o = sel_q; EX requests ignored (wrong path).
//   - Counter starts at FLUSH_CYCLES-1 and decrements on each cycle with !pc_stall_i; it freezes
//     while stalled.
//   - Exit to IDLE on the cycle the counter reaches 0, so flush_o is high for exactly FLUSH_CYCLES
//     unstalled cycles in total.
// Latency and counter
// - Redirect latency is 0 cycles from req in IDLE: the PC takes the target at the next edge.
// - redirect_cnt_o increments on every cycle with redirect_o = 1 and saturates at all-ones.
// Simultaneous events
// - req arriving on the FLUSH exit cycle is ignored; it belongs to the wrong path.
// - The cycle after FLUSH exit is IDLE and accepts requests normally.
// STRUCTURE
// - next_pc_defs.vh (shared include):
//   - ADDCTL_BRANCH = 2'd0, ADDCTL_JR = 2'd1, ADDCTL_JUMP = 2'd2
//   - state encodings S_IDLE = 2'd0, S_HOLD = 2'd1, S_FLUSH = 2'd2
// - One sub-module, sat_counter (parameter W; inc, clr; async active-low reset), used for
//   redirect_cnt_o.
// - FSM, selection register and flush down-counter stay in this module.
// TESTING
// - T1 taken branch: ex_valid=1, branch=1, taken=1, stall=0 ->
//   same cycle adder_ctrl=0, redirect=1, flush=1; flush high 2 cycles total; cnt=1.
// - T2 priority: jump=1, jr=1, valid=1 -> adder_ctrl=2, redirect=1, multi_err=1 stays 1
//   after inputs clear.
// - T3 stalled jr: jr=1, stall=1 for 3 cycles -> redirect=0, busy=1, adder_ctrl=1 held.
//   Stall drops -> redirect=1 for exactly 1 cycle, then 1 more flush cycle.
// - T4 wrong-path: jump redirect, then branch+taken in the following FLUSH cycle ->
//   no second redirect; cnt=1.
// - T5 reset mid-FLUSH: Reset_n low during FLUSH -> all outputs 0 immediately.
//   After release, idle with valid=0 -> redirect=0.
// - T6 saturation: CNT_W=2, five redirects -> redirect_cnt_o = 3.

Source files
------------

// File: rtl/next_pc_controller_pkg.sv
// Shared definitions for the next-PC controller: adder select codes, FSM states
// and the target-source priority helper.
package next_pc_controller_pkg;

  // Next-PC adder source select
  localparam logic [1:0] ADDCTL_BRANCH = 2'd0;
  localparam logic [1:0] ADDCTL_JR     = 2'd1;
  localparam logic [1:0] ADDCTL_JUMP   = 2'd2;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  // Target source priority: jump > jr > taken branch.
  function automatic logic [1:0] sel_for(input logic jump, input logic jr);
    logic [1:0] sel;
    if (jump) begin
      sel = ADDCTL_JUMP;
    end else if (jr) begin
      sel = ADDCTL_JR;
    end else begin
      sel = ADDCTL_BRANCH;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;

  // Count state: clear wins over increment, increment stops at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/next_pc_controller.sv
// Next-PC controller: turns EX-stage branch/jump resolution into the next-PC adder
// select, a PC redirect strobe and a pipeline flush window. A redirect requested
// while the front end is stalled is parked in HOLD until the stall lifts.
module next_pc_controller
  import next_pc_controller_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             ex_valid_i,
  input  logic             ex_branch_i,
  input  logic             ex_taken_i,
  input  logic             ex_jr_i,
  input  logic             ex_jump_i,
  input  logic             pc_stall_i,
  output logic [1:0]       adder_ctrl_o,
  output logic             redirect_o,
  output logic             flush_o,
  output logic             busy_o,
  output logic             multi_err_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  // Remaining unstalled FLUSH cycles after the redirect cycle itself
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 1);

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic       merr_q, merr_d;

  logic       br_taken;
  logic       req;
  logic       multi;
  logic [1:0] new_sel;

  assign br_taken = ex_branch_i & ex_taken_i;
  assign req      = ex_valid_i & (ex_jump_i | ex_jr_i | br_taken);
  assign multi    = ex_valid_i &
                    ((ex_jump_i & ex_jr_i) | (ex_jump_i & br_taken) | (ex_jr_i & br_taken));
  assign new_sel  = sel_for(ex_jump_i, ex_jr_i);

  // State, selection, flush counter and sticky error registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      sel_q   <= ADDCTL_BRANCH;
      fcnt_q  <= '0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      fcnt_q  <= fcnt_d;
      merr_q  <= merr_d;
    end
  end

  // Next-state and Mealy outputs
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    fcnt_d       = fcnt_q;
    merr_d       = merr_q | multi;
    adder_ctrl_o = sel_q;
    redirect_o   = 1'b0;
    flush_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          sel_d        = new_sel;
          adder_ctrl_o = new_sel;
          if (pc_stall_i) begin
            state_d = S_HOLD;
          end else begin
            redirect_o = 1'b1;
            flush_o    = 1'b1;
            if (HAS_FLUSH) begin
              state_d = S_FLUSH;
              fcnt_d  = FLUSH_INIT;
            end
          end
        end
      end

      S_HOLD: begin
        // Parked redirect; younger EX requests are on the wrong path
        if (!pc_stall_i) begin
          redirect_o = 1'b1;
          flush_o    = 1'b1;
          if (HAS_FLUSH) begin
            state_d = S_FLUSH;
            fcnt_d  = FLUSH_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_FLUSH: begin
        flush_o = 1'b1;
        // Only unstalled cycles actually clear a pipeline slot
        if (!pc_stall_i) begin
          fcnt_d = fcnt_q - 3'd1;
          if (fcnt_q <= 3'd1) begin
            state_d = S_IDLE;
            fcnt_d  = '0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o      = (state_q != S_IDLE);
  assign multi_err_o = merr_q;

  sat_counter #(
    .W (CNT_W)
  ) u_redirect_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .inc   (redirect_o),
    .clr   (1'b0),
    .count (redirect_cnt_o)
  );

endmodule

// File: tb/tb_next_pc_controller.sv
// Bench for next_pc_controller. Instance A uses defaults (2 flush cycles, 16-bit
// counter); instance B shares A's inputs with 3 flush cycles and a 2-bit counter.
module tb_next_pc_controller;

  logic Clk = 1'b0;
  logic Reset_n;
  logic v, b, t, jr, j, st;

  logic [1:0]  a_ctrl, b_ctrl;
  logic        a_redir, a_flush, a_busy, a_merr;
  logic        b_redir, b_flush, b_busy, b_merr;
  logic [15:0] a_cnt;
  logic [1:0]  b_cnt;

  always #5 Clk = ~Clk;

  next_pc_controller dut_a (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .ex_valid_i     (v),
    .ex_branch_i    (b),
    .ex_taken_i     (t),
    .ex_jr_i        (jr),
    .ex_jump_i      (j),
    .pc_stall_i     (st),
    .adder_ctrl_o   (a_ctrl),
    .redirect_o     (a_redir),
    .flush_o        (a_flush),
    .busy_o         (a_busy),
    .multi_err_o    (a_merr),
    .redirect_cnt_o (a_cnt)
  );

  next_pc_controller #(
    .FLUSH_CYCLES (3),
    .CNT_W        (2)
  ) dut_b (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .ex_valid_i     (v),
    .ex_branch_i    (b),
    .ex_taken_i     (t),
    .ex_jr_i        (jr),
    .ex_jump_i      (j),
    .pc_stall_i     (st),
    .adder_ctrl_o   (b_ctrl),
    .redirect_o     (b_redir),
    .flush_o        (b_flush),
    .busy_o         (b_busy),
    .multi_err_o    (b_merr),
    .redirect_cnt_o (b_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per instance, pending parked redirect, unstalled flush
  // cycles still owed, last selected source and redirect count.
  int fcyc[2] = '{2, 3};
  int cmax[2] = '{65535, 3};
  int flush_left[2];
  bit pend[2];
  int sel[2];
  int cnt[2];
  bit merr;

  typedef struct {
    bit v, b, t, jr, j, st;
    int ctrl, redir, flush, busy, merr, cnt;  // ctrl < 0: not checked
  } vec_t;

  vec_t tab[20];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      flush_left[k] = 0;
      pend[k]       = 1'b0;
      sel[k]        = 0;
      cnt[k]        = 0;
    end
    merr = 1'b0;
  endfunction

  function automatic bit cur_req();
    return v && (j || jr || (b && t));
  endfunction

  function automatic int cur_sel();
    return j ? 2 : (jr ? 1 : 0);
  endfunction

  function automatic void model_out(input int k, output int ctrl, output int redir,
                                    output int flush, output int busy);
    if (flush_left[k] > 0) begin
      ctrl = sel[k]; redir = 0; flush = 1; busy = 1;
    end else if (pend[k]) begin
      ctrl = sel[k]; busy = 1; redir = st ? 0 : 1; flush = redir;
    end else begin
      busy = 0;
      if (cur_req()) begin
        ctrl  = st ? -1 : cur_sel();
        redir = st ? 0 : 1;
        flush = redir;
      end else begin
        ctrl = sel[k]; redir = 0; flush = 0;
      end
    end
  endfunction

  function automatic void model_step(input int k);
    bit fired = 1'b0;
    if (flush_left[k] > 0) begin
      if (!st) flush_left[k]--;
    end else if (pend[k]) begin
      if (!st) begin
        pend[k] = 1'b0; flush_left[k] = fcyc[k] - 1; fired = 1'b1;
      end
    end else if (cur_req()) begin
      sel[k] = cur_sel();
      if (st) pend[k] = 1'b1;
      else begin
        flush_left[k] = fcyc[k] - 1; fired = 1'b1;
      end
    end
    if (fired && cnt[k] < cmax[k]) cnt[k]++;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    if (exp >= 0) begin
      n_cmp++;
      if (got != exp) begin
        n_bad++;
        $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
      end
    end
  endtask

  task automatic set_in(input bit iv, ib, it, ijr, ij, ist);
    v = iv; b = ib; t = it; jr = ijr; j = ij; st = ist;
  endtask

  // One cycle: inputs already applied; check mid-cycle, then advance models.
  task automatic cycle(input bit use_tab, input vec_t e);
    int c0, r0, f0, y0, c1, r1, f1, y1;
    @(negedge Clk);
    model_out(0, c0, r0, f0, y0);
    model_out(1, c1, r1, f1, y1);
    if (use_tab) begin
      c0 = e.ctrl; r0 = e.redir; f0 = e.flush; y0 = e.busy;
    end
    check("a_ctrl", int'(a_ctrl), c0);
    check("a_redirect", int'(a_redir), r0);
    check("a_flush", int'(a_flush), f0);
    check("a_busy", int'(a_busy), y0);
    check("a_multi_err", int'(a_merr), use_tab ? e.merr : int'(merr));
    check("a_cnt", int'(a_cnt), use_tab ? e.cnt : cnt[0]);
    check("b_ctrl", int'(b_ctrl), c1);
    check("b_redirect", int'(b_redir), r1);
    check("b_flush", int'(b_flush), f1);
    check("b_busy", int'(b_busy), y1);
    check("b_multi_err", int'(b_merr), int'(merr));
    check("b_cnt", int'(b_cnt), cnt[1]);
    @(posedge Clk);
    model_step(0);
    model_step(1);
    if (v && ((int'(j) + int'(jr) + int'(b && t)) >= 2)) merr = 1'b1;
    #1;
  endtask

  initial begin
    vec_t dummy;
    // v b t jr j st | ctrl redir flush busy merr cnt  (instance A, from reset)
    tab[0]  = '{0,0,0,0,0,0,  0,0,0,0,0,0};
    tab[1]  = '{1,1,1,0,0,0,  0,1,1,0,0,0};  // taken branch
    tab[2]  = '{0,0,0,0,0,0,  0,0,1,1,0,1};
    tab[3]  = '{0,0,0,0,0,0,  0,0,0,0,0,1};
    tab[4]  = '{1,0,0,1,1,0,  2,1,1,0,0,1};  // jump beats jr
    tab[5]  = '{0,0,0,0,0,0,  2,0,1,1,1,2};
    tab[6]  = '{0,0,0,0,0,0,  2,0,0,0,1,2};
    tab[7]  = '{1,0,0,0,1,0,  2,1,1,0,1,2};  // jump
    tab[8]  = '{1,1,1,0,0,0,  2,0,1,1,1,3};  // wrong-path branch on FLUSH exit
    tab[9]  = '{0,0,0,0,0,0,  2,0,0,0,1,3};
    tab[10] = '{1,0,0,1,0,1, -1,0,0,0,1,3};  // stalled jr
    tab[11] = '{1,0,0,1,0,1,  1,0,0,1,1,3};
    tab[12] = '{1,1,1,0,0,1,  1,0,0,1,1,3};
    tab[13] = '{0,0,0,0,0,0,  1,1,1,1,1,3};  // stall drops
    tab[14] = '{0,0,0,0,0,0,  1,0,1,1,1,4};
    tab[15] = '{0,0,0,0,0,0,  1,0,0,0,1,4};
    tab[16] = '{1,0,0,0,1,0,  2,1,1,0,1,4};
    tab[17] = '{0,0,0,0,0,1,  2,0,1,1,1,5};  // stalled FLUSH freezes
    tab[18] = '{0,0,0,0,0,0,  2,0,1,1,1,5};
    tab[19] = '{0,0,0,0,0,0,  2,0,0,0,1,5};
    dummy = tab[0];

    Reset_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    #12 Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      set_in(tab[i].v, tab[i].b, tab[i].t, tab[i].jr, tab[i].j, tab[i].st);
      cycle(1'b1, tab[i]);
    end
    // Five redirects into a 2-bit counter
    check("b_cnt_saturated", int'(b_cnt), 3);

    // Reset while in FLUSH
    set_in(1, 0, 0, 0, 1, 0);
    cycle(1'b0, dummy);
    set_in(0, 0, 0, 0, 0, 0);
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_a_ctrl", int'(a_ctrl), 0);
    check("rst_a_redirect", int'(a_redir), 0);
    check("rst_a_flush", int'(a_flush), 0);
    check("rst_a_busy", int'(a_busy), 0);
    check("rst_a_multi_err", int'(a_merr), 0);
    check("rst_a_cnt", int'(a_cnt), 0);
    check("rst_b_busy", int'(b_busy), 0);
    check("rst_b_flush", int'(b_flush), 0);
    #3 Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    cycle(1'b0, dummy);
    cycle(1'b0, dummy);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0);
      cycle(1'b0, dummy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
